core_mem_arbiter: RTL and testbench

- Shares one memory bus port between the core's instruction-fetch and data-access interfaces.
- Both masters use the core's req/gnt/rvalid protocol.
- Sits between the core top and the single memory/bus slave.
- Data requests have fixed priority. A starvation counter guarantees fetch progress.
- In-order responses are routed back using an owner FIFO that tracks outstanding transactions.

---
 rtl/core_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Shares one memory bus port between the fetch and data interfaces using fixed data priority
// with a fetch-starvation guard; responses are routed in order through an owner FIFO.
module core_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned STV_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [STV_W-1:0]           starve_q, starve_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic                       perr_q, perr_d;

  logic live;
  logic sel_instr, sel_data, sel_req;
  logic fifo_full, fifo_empty, head_data;
  logic accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Combinational outputs are forced low while reset is held
  assign live       = ~rst;
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head_data  = owner_q[rd_ptr_q];

  // Master selection: a lock pins the master until its handshake completes
  always_comb begin
    sel_instr = 1'b0;
    sel_data  = 1'b0;
    case (state_q)
      LOCK_I:  sel_instr = 1'b1;
      LOCK_D:  sel_data  = 1'b1;
      default: begin
        if (data_req_i && instr_req_i) begin
          if (starve_q == STV_W'(STARVE_LIMIT)) sel_instr = 1'b1;
          else                                  sel_data  = 1'b1;
        end else if (data_req_i) begin
          sel_data = 1'b1;
        end else if (instr_req_i) begin
          sel_instr = 1'b1;
        end
      end
    endcase
  end

  assign sel_req   = (sel_instr & instr_req_i) | (sel_data & data_req_i);
  assign bus_req_o = live & sel_req & ~fifo_full;
  assign accept    = bus_req_o & bus_gnt_i;
  assign push      = accept;
  assign pop       = live & bus_rvalid_i & ~fifo_empty;

  assign instr_gnt_o = accept & sel_instr;
  assign data_gnt_o  = accept & sel_data;

  // Bus payload mux; fetches are always full-word reads
  always_comb begin
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    if (live && sel_instr) begin
      bus_be_o   = 4'hF;
      bus_addr_o = instr_addr_i;
    end else if (live && sel_data) begin
      bus_we_o    = data_we_i;
      bus_be_o    = data_be_i;
      bus_addr_o  = data_addr_i;
      bus_wdata_o = data_wdata_i;
    end
  end

  // Next state, starvation counter, owner FIFO and sticky protocol error
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    perr_d   = perr_q;

    if (accept || !sel_req) begin
      state_d = IDLE;
    end else if (bus_req_o) begin
      state_d = sel_instr ? LOCK_I : LOCK_D;
    end

    if (!instr_req_i || (accept && sel_instr)) begin
      starve_d = '0;
    end else if (accept && sel_data && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end

    if (push) begin
      owner_d[wr_ptr_q] = sel_data;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (live && bus_rvalid_i && fifo_empty) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      perr_q   <= perr_d;
    end
  end

  // In-order response routing from the FIFO head; non-owner sees zeros
  assign instr_rvalid_o = pop & ~head_data;
  assign data_rvalid_o  = pop &  head_data;
  assign instr_rdata_o  = instr_rvalid_o ? bus_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o  ? bus_rdata_i : 32'h0;
  assign instr_err_o    = instr_rvalid_o & bus_err_i;
  assign data_err_o     = data_rvalid_o  & bus_err_i;

  assign outstanding_o  = cnt_q;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for contention, locking, protocol error and reset.
module tb_core_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  core_mem_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        e_breq;
    logic [31:0] e_baddr;
    logic        e_bwe;
    logic [3:0]  e_bbe;
    logic [31:0] e_bwd;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
    logic        e_ierr;
    logic        e_derr;
    logic [1:0]  e_out;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0; instr_addr_i = 32'h0;
    data_req_i   = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i  = 32'h0; data_wdata_i = 32'h0;
    bus_gnt_i    = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " bus_req"},   {31'h0, bus_req_o},      32'h0);
    chk({tag, " bus_addr"},  bus_addr_o,              32'h0);
    chk({tag, " bus_be"},    {28'h0, bus_be_o},       32'h0);
    chk({tag, " bus_we"},    {31'h0, bus_we_o},       32'h0);
    chk({tag, " gnts"},      {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
    chk({tag, " rvalids"},   {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    chk({tag, " errs"},      {30'h0, instr_err_o, data_err_o}, 32'h0);
    chk({tag, " outst"},     {30'h0, outstanding_o},  32'h0);
    chk({tag, " perr"},      {31'h0, protocol_err_o}, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    @(negedge clk);
    instr_req_i = v.ireq;  instr_addr_i = v.iaddr;
    data_req_i  = v.dreq;  data_we_i = v.dwe; data_be_i = v.dbe;
    data_addr_i = v.daddr; data_wdata_i = v.dwd;
    bus_gnt_i   = v.gnt;   bus_rvalid_i = v.rv; bus_rdata_i = v.rdata; bus_err_i = v.err;
    #1;
    t = $sformatf("vec%0d", idx);
    chk({t, " bus_req"},  {31'h0, bus_req_o},     {31'h0, v.e_breq});
    chk({t, " bus_addr"}, bus_addr_o,             v.e_baddr);
    chk({t, " bus_we"},   {31'h0, bus_we_o},      {31'h0, v.e_bwe});
    chk({t, " bus_be"},   {28'h0, bus_be_o},      {28'h0, v.e_bbe});
    chk({t, " bus_wdata"}, bus_wdata_o,           v.e_bwd);
    chk({t, " instr_gnt"}, {31'h0, instr_gnt_o},  {31'h0, v.e_ig});
    chk({t, " data_gnt"}, {31'h0, data_gnt_o},    {31'h0, v.e_dg});
    chk({t, " instr_rvalid"}, {31'h0, instr_rvalid_o}, {31'h0, v.e_irv});
    chk({t, " data_rvalid"},  {31'h0, data_rvalid_o},  {31'h0, v.e_drv});
    chk({t, " instr_rdata"}, instr_rdata_o,       v.e_ird);
    chk({t, " data_rdata"},  data_rdata_o,        v.e_drd);
    chk({t, " instr_err"}, {31'h0, instr_err_o},  {31'h0, v.e_ierr});
    chk({t, " data_err"},  {31'h0, data_err_o},   {31'h0, v.e_derr});
    chk({t, " outstanding"}, {30'h0, outstanding_o}, {30'h0, v.e_out});
  endtask

  initial begin
    // Single fetch and its response
    vecs[0]  = '{default: '0};
    vecs[1]  = '{ireq: 1'b1, iaddr: 32'h100, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h100, e_bbe: 4'hF, e_ig: 1'b1, default: '0};
    vecs[2]  = '{rv: 1'b1, rdata: 32'h13, e_irv: 1'b1, e_ird: 32'h13, e_out: 2'd1, default: '0};
    // Mixed ordering: data read then fetch, responses AA then BB (with error)
    vecs[3]  = '{dreq: 1'b1, dbe: 4'hF, daddr: 32'h200, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h200, e_bbe: 4'hF, e_dg: 1'b1, default: '0};
    vecs[4]  = '{ireq: 1'b1, iaddr: 32'h104, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h104, e_bbe: 4'hF, e_ig: 1'b1, e_out: 2'd1, default: '0};
    vecs[5]  = '{rv: 1'b1, rdata: 32'hAA, e_drv: 1'b1, e_drd: 32'hAA, e_out: 2'd2, default: '0};
    vecs[6]  = '{rv: 1'b1, rdata: 32'hBB, err: 1'b1,
                 e_irv: 1'b1, e_ird: 32'hBB, e_ierr: 1'b1, e_out: 2'd1, default: '0};
    // Data write payload passes through
    vecs[7]  = '{dreq: 1'b1, dwe: 1'b1, dbe: 4'h3, daddr: 32'h300, dwd: 32'hDEADBEEF, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h300, e_bwe: 1'b1, e_bbe: 4'h3, e_bwd: 32'hDEADBEEF,
                 e_dg: 1'b1, default: '0};
    vecs[8]  = '{rv: 1'b1, e_drv: 1'b1, e_out: 2'd1, default: '0};
    // Fill the FIFO, blocked presentation, pop, re-presentation, drain
    vecs[9]  = '{dreq: 1'b1, dbe: 4'hF, daddr: 32'h400, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h400, e_bbe: 4'hF, e_dg: 1'b1, default: '0};
    vecs[10] = '{dreq: 1'b1, dbe: 4'hF, daddr: 32'h400, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h400, e_bbe: 4'hF, e_dg: 1'b1, e_out: 2'd1, default: '0};
    vecs[11] = '{ireq: 1'b1, iaddr: 32'h120, dreq: 1'b1, dbe: 4'hF, daddr: 32'h400, gnt: 1'b1,
                 e_baddr: 32'h400, e_bbe: 4'hF, e_out: 2'd2, default: '0};
    vecs[12] = '{ireq: 1'b1, iaddr: 32'h120, dreq: 1'b1, dbe: 4'hF, daddr: 32'h400, gnt: 1'b1,
                 rv: 1'b1, rdata: 32'h11,
                 e_baddr: 32'h400, e_bbe: 4'hF, e_drv: 1'b1, e_drd: 32'h11, e_out: 2'd2, default: '0};
    vecs[13] = '{ireq: 1'b1, iaddr: 32'h120, dreq: 1'b1, dbe: 4'hF, daddr: 32'h400, gnt: 1'b1,
                 e_breq: 1'b1, e_baddr: 32'h400, e_bbe: 4'hF, e_dg: 1'b1, e_out: 2'd1, default: '0};
    vecs[14] = '{rv: 1'b1, rdata: 32'h22, e_drv: 1'b1, e_drd: 32'h22, e_out: 2'd2, default: '0};
    vecs[15] = '{rv: 1'b1, rdata: 32'h33, e_drv: 1'b1, e_drd: 32'h33, e_out: 2'd1, default: '0};

    // Reset with active inputs: everything must read zero
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    instr_req_i = 1'b1; instr_addr_i = 32'h55; data_req_i = 1'b1; data_be_i = 4'hF;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("drained outstanding", {30'h0, outstanding_o}, 32'h0);

    // Contention with continuous grant: D,D,D,D,I repeating
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      @(negedge clk);
      instr_req_i = 1'b1; instr_addr_i = 32'h500;
      data_req_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h600;
      bus_gnt_i = 1'b1; bus_rvalid_i = (k > 0);
      #1;
      exp_i = (k == 4) || (k == 9);
      chk($sformatf("contend%0d instr_gnt", k), {31'h0, instr_gnt_o}, {31'h0, exp_i});
      chk($sformatf("contend%0d data_gnt", k),  {31'h0, data_gnt_o},  {31'h0, ~exp_i});
      chk($sformatf("contend%0d bus_addr", k),  bus_addr_o, exp_i ? 32'h500 : 32'h600);
    end
    @(negedge clk);
    idle_inputs();
    bus_rvalid_i = 1'b1;
    #1;
    chk("contend drain instr_rvalid", {31'h0, instr_rvalid_o}, 32'h1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("contend outstanding", {30'h0, outstanding_o}, 32'h0);
    chk("perr still clear", {31'h0, protocol_err_o}, 32'h0);

    // Response with nothing outstanding is dropped and flagged
    @(negedge clk);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55; bus_err_i = 1'b1;
    #1;
    chk("stray rvalids", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    chk("stray rdata", instr_rdata_o | data_rdata_o, 32'h0);
    chk("stray errs", {30'h0, instr_err_o, data_err_o}, 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("perr set", {31'h0, protocol_err_o}, 32'h1);
    @(negedge clk);
    #1;
    chk("perr sticky", {31'h0, protocol_err_o}, 32'h1);

    // Lock: fetch held for three stalled cycles while data arrives
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      instr_req_i = (c < 4); instr_addr_i = 32'h700;
      data_req_i = (c >= 1); data_be_i = 4'hF; data_addr_i = 32'h800;
      bus_gnt_i = (c == 3);
      #1;
      chk($sformatf("lock%0d bus_req", c), {31'h0, bus_req_o}, 32'h1);
      chk($sformatf("lock%0d bus_addr", c), bus_addr_o, (c < 4) ? 32'h700 : 32'h800);
      chk($sformatf("lock%0d instr_gnt", c), {31'h0, instr_gnt_o}, {31'h0, c == 3});
      chk($sformatf("lock%0d data_gnt", c), {31'h0, data_gnt_o}, 32'h0);
    end
    @(negedge clk);
    #1;
    chk("locked data addr", bus_addr_o, 32'h800);
    chk("locked outstanding", {30'h0, outstanding_o}, 32'h1);

    // Reset mid-lock with one outstanding clears everything immediately
    @(negedge clk);
    rst = 1'b1; bus_rvalid_i = 1'b1; bus_gnt_i = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post reset perr", {31'h0, protocol_err_o}, 32'h0);
    chk("post reset outstanding", {30'h0, outstanding_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
